// File: rtl/stepper_pkg.sv
// ---------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the stepper lift controller:
//   - lift_state_e    : stroke sequencer states
//   - FULL_STEP_TABLE : 4-phase full-step coil patterns, indexed by phase
//   - HALF_STEP_TABLE : 8-phase half-step coil patterns, indexed by phase
//   - phase_to_coils  : maps a 3-bit phase to the 4-bit coil pattern
// ---------------------------------------------------------------------------
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOWN,
    ST_DWELL,
    ST_UP,
    ST_HOLD
  } lift_state_e;

  // Element [0] is the rightmost entry of each concatenation.
  localparam logic [3:0][3:0] FULL_STEP_TABLE = {
    4'b1001, 4'b0011, 4'b0110, 4'b1100
  };

  localparam logic [7:0][3:0] HALF_STEP_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // Full-step mode only looks at the low two phase bits, so a phase
  // counter that wraps modulo 4 always lands inside the table.
  function automatic logic [3:0] phase_to_coils(input logic [2:0] phase,
                                                input logic       half_step);
    logic [3:0] coils;
    if (half_step) begin
      coils = HALF_STEP_TABLE[phase];
    end else begin
      coils = FULL_STEP_TABLE[phase[1:0]];
    end
    return coils;
  endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// ---------------------------------------------------------------------------
// stepper_phase_gen
// One motor's phase sequencer. Holds a 3-bit phase that advances by one on
// each step pulse (decrements when dir=1), wrapping modulo 4 in full-step
// mode or modulo 8 in half-step mode, and registers the matching coil
// pattern. The coil pattern follows the updated phase in the same cycle the
// step is taken.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (phase and coils to 0)
//   step  in  advance the phase this cycle
//   dir   in  0 = phase increments, 1 = phase decrements
//   blank in  force the registered coil output to 0000
//   coils out registered 4-bit coil drive
// ---------------------------------------------------------------------------
module stepper_phase_gen
  import stepper_pkg::*;
#(
  parameter int HALF_STEP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic       blank,
  output logic [3:0] coils
);

  logic [2:0] phase_q, phase_d;
  logic [3:0] coils_q, coils_d;

  // Next phase and next coil pattern. In full-step mode the top phase bit
  // is held at zero so the 3-bit arithmetic wraps modulo 4. Blanking only
  // gates the coils; the phase keeps tracking the mechanical position.
  always_comb begin
    phase_d = phase_q;
    if (step) begin
      phase_d = dir ? (phase_q - 3'd1) : (phase_q + 3'd1);
    end
    if (HALF_STEP == 0) begin
      phase_d[2] = 1'b0;
    end
    coils_d = blank ? 4'b0000 : phase_to_coils(phase_d, (HALF_STEP != 0));
  end

  // Phase and coil registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      coils_q <= '0;
    end else begin
      phase_q <= phase_d;
      coils_q <= coils_d;
    end
  end

  assign coils = coils_q;

endmodule

// File: rtl/stepper_lift_ctrl.sv
// ---------------------------------------------------------------------------
// stepper_lift_ctrl
// Drives N_MOT stepper motors in lock-step through a latched
// down / dwell / up / hold-off stroke started by an active-low IR sensor.
// An abort request during descent or dwell retraces the steps already taken.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   ir_trig   in  IR sensor, 0 = bottle present (starts a stroke from idle)
//   abort     in  retract request, honoured in DOWN and DWELL only
//   motor_out out coil drive, motor i on [4i+3:4i]
//   busy      out high whenever the sequencer is not idle
//   at_bottom out high while dwelling at the bottom of the stroke
//   done      out one-cycle pulse after entering the hold-off period
// ---------------------------------------------------------------------------
module stepper_lift_ctrl
  import stepper_pkg::*;
#(
  parameter int               N_MOT      = 2,
  parameter int               STEP_DELAY = 200000,
  parameter int               STROKE     = 850,
  parameter int               DWELL      = 50_000_000,
  parameter int               HOLDOFF    = 300_000_000,
  parameter int               HALF_STEP  = 0,
  parameter logic [N_MOT-1:0] DIR_MASK   = 2'b10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_trig,
  input  logic               abort,
  output logic [4*N_MOT-1:0] motor_out,
  output logic               busy,
  output logic               at_bottom,
  output logic               done
);

  localparam int POS_W = $clog2(STROKE + 1);

  lift_state_e      state_q, state_d;
  logic [31:0]      tick_q, tick_d;
  logic [31:0]      wait_q, wait_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_q, done_d;
  logic             tick_wrap;
  logic             step_en;
  logic             ascend;
  logic             blank;

  assign tick_wrap = (tick_q == 32'(STEP_DELAY - 1));

  // Stroke sequencer. The tick counter paces steps in DOWN and UP; wait_q
  // is shared between the dwell and hold-off periods since they never
  // overlap. Abort takes priority over a coincident descent tick, so that
  // tick's step is dropped and the ascent retraces exactly pos_q steps.
  // Coils are blanked based on the state being entered so they are already
  // off on the edge that enters HOLD or IDLE.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    wait_d  = wait_q;
    pos_d   = pos_q;
    step_en = 1'b0;
    ascend  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ir_trig) begin
          state_d = ST_DOWN;
          tick_d  = '0;
          pos_d   = '0;
        end
      end

      ST_DOWN: begin
        if (abort) begin
          tick_d = '0;
          wait_d = '0;
          state_d = (pos_q == '0) ? ST_HOLD : ST_UP;
        end else if (tick_wrap) begin
          tick_d  = '0;
          step_en = 1'b1;
          pos_d   = pos_q + POS_W'(1);
          if (pos_q == POS_W'(STROKE - 1)) begin
            state_d = ST_DWELL;
            wait_d  = '0;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      ST_DWELL: begin
        if (abort || (wait_q == 32'(DWELL - 1))) begin
          state_d = ST_UP;
          tick_d  = '0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      ST_UP: begin
        ascend = 1'b1;
        if (tick_wrap) begin
          tick_d  = '0;
          step_en = 1'b1;
          pos_d   = pos_q - POS_W'(1);
          if (pos_q == POS_W'(1)) begin
            state_d = ST_HOLD;
            wait_d  = '0;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      ST_HOLD: begin
        if (wait_q == 32'(HOLDOFF - 1)) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_HOLD) && (state_q != ST_HOLD);
    blank  = (state_d == ST_IDLE) || (state_d == ST_HOLD);
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      wait_q  <= '0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      wait_q  <= wait_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end

  // One phase generator per motor. A set DIR_MASK bit flips the phase
  // direction so that motor decrements on descent and increments on ascent.
  for (genvar i = 0; i < N_MOT; i++) begin : g_mot
    stepper_phase_gen #(
      .HALF_STEP(HALF_STEP)
    ) u_phase_gen (
      .clk  (clk),
      .rst  (rst),
      .step (step_en),
      .dir  (DIR_MASK[i] ^ ascend),
      .blank(blank),
      .coils(motor_out[4*i +: 4])
    );
  end

  assign busy      = (state_q != ST_IDLE);
  assign at_bottom = (state_q == ST_DWELL);
  assign done      = done_q;

endmodule
